// File: rtl/poly_axis_tx.sv
// rtl/poly_axis_tx.sv - ping-pong operand buffer streaming p/u coefficient pairs in lockstep
module poly_axis_tx #(
  parameter int N  = 4,
  parameter int QW = 5,
  parameter int UW = 1
) (
  input  logic                  clk_i,
  input  logic                  s_rst_i,
  input  logic                  wr_en_i,
  input  logic                  wr_sel_i,
  input  logic [$clog2(N)-1:0]  wr_addr_i,
  input  logic [QW-1:0]         wr_data_i,
  input  logic                  commit_i,
  output logic                  bank_full_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [QW-1:0]         p_data_o,
  output logic                  p_vld_o,
  output logic                  p_last_o,
  input  logic                  p_rdy_i,
  output logic [UW-1:0]         u_data_o,
  output logic                  u_vld_o,
  output logic                  u_last_o,
  input  logic                  u_rdy_i
);

  localparam int AW = $clog2(N);
  localparam int IW = AW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [AW-1:0] IDX0     = '0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Coefficient storage: [bank][index]; never reset, only overwritten.
  logic [QW-1:0] mem_p_q [2][N];
  logic [UW-1:0] mem_u_q [2][N];

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    loaded_q, loaded_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic [QW-1:0] p_data_q, p_data_d;
  logic [UW-1:0] u_data_q, u_data_d;
  logic          err_q, err_d;

  logic          bank_full;
  logic          wr_ok;
  logic          commit_ok;
  logic          fire;
  logic          rdy_mismatch;
  logic [IW-1:0] idx_inc;

  assign bank_full    = loaded_q[0] & loaded_q[1];
  assign wr_ok        = wr_en_i & ~bank_full & ({1'b0, wr_addr_i} < LAST_IDX + 1'b1);
  assign commit_ok    = commit_i & ~bank_full & ~loaded_q[wb_q];
  assign fire         = vld_q & p_rdy_i & u_rdy_i;
  assign rdy_mismatch = vld_q & (p_rdy_i ^ u_rdy_i);
  assign idx_inc      = idx_q + 1'b1;

  // Write port: coefficients land in the current write bank; blocked during reset.
  always_ff @(posedge clk_i) begin
    if (!s_rst_i && wr_ok) begin
      if (wr_sel_i) begin
        mem_u_q[wb_q][wr_addr_i] <= wr_data_i[UW-1:0];
      end else begin
        mem_p_q[wb_q][wr_addr_i] <= wr_data_i;
      end
    end
  end

  // Next-state: bank bookkeeping, stream sequencing and registered beat outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    loaded_d = loaded_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    vld_d    = vld_q;
    last_d   = last_q;
    p_data_d = p_data_q;
    u_data_d = u_data_q;
    err_d    = err_q | rdy_mismatch;

    // A write in the same cycle reaches memory at this edge, before the bank is read.
    if (commit_ok) begin
      loaded_d[wb_q] = 1'b1;
      wb_d           = ~wb_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (loaded_q[rb_q]) begin
          state_d  = ST_SEND;
          vld_d    = 1'b1;
          idx_d    = '0;
          p_data_d = mem_p_q[rb_q][IDX0];
          u_data_d = mem_u_q[rb_q][IDX0];
          last_d   = 1'b0; // N >= 2, so coeff 0 is never the last
        end
      end
      ST_SEND: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            loaded_d[rb_q] = 1'b0;
            rb_d           = ~rb_q;
            idx_d          = '0;
            last_d         = 1'b0;
            if (loaded_q[~rb_q]) begin
              p_data_d = mem_p_q[~rb_q][IDX0];
              u_data_d = mem_u_q[~rb_q][IDX0];
            end else begin
              state_d  = ST_IDLE;
              vld_d    = 1'b0;
              p_data_d = '0;
              u_data_d = '0;
            end
          end else begin
            idx_d    = idx_inc;
            p_data_d = mem_p_q[rb_q][idx_inc[AW-1:0]];
            u_data_d = mem_u_q[rb_q][idx_inc[AW-1:0]];
            last_d   = (idx_inc == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset; reset aborts any stream in flight.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      loaded_q <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      p_data_q <= '0;
      u_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      p_data_q <= p_data_d;
      u_data_q <= u_data_d;
      err_q    <= err_d;
    end
  end

  assign bank_full_o = bank_full;
  assign busy_o      = (state_q == ST_SEND);
  assign err_o       = err_q;
  assign p_data_o    = p_data_q;
  assign p_vld_o     = vld_q;
  assign p_last_o    = last_q;
  assign u_data_o    = u_data_q;
  assign u_vld_o     = vld_q;
  assign u_last_o    = last_q;

endmodule

// File: tb/tb_poly_axis_tx.sv
// tb/tb_poly_axis_tx.sv - self-checking bench for poly_axis_tx
module tb_poly_axis_tx;
  localparam int N  = 4;
  localparam int QW = 5;
  localparam int UW = 1;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          s_rst_i = 1'b1;
  logic          wr_en_i = 1'b0;
  logic          wr_sel_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [QW-1:0] wr_data_i = '0;
  logic          commit_i = 1'b0;
  logic          bank_full_o, busy_o, err_o;
  logic [QW-1:0] p_data_o;
  logic          p_vld_o, p_last_o;
  logic          p_rdy_i = 1'b0;
  logic [UW-1:0] u_data_o;
  logic          u_vld_o, u_last_o;
  logic          u_rdy_i = 1'b0;

  always #5 clk = ~clk;

  poly_axis_tx #(.N(N), .QW(QW), .UW(UW)) dut (
    .clk_i(clk), .s_rst_i(s_rst_i), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .commit_i(commit_i),
    .bank_full_o(bank_full_o), .busy_o(busy_o), .err_o(err_o),
    .p_data_o(p_data_o), .p_vld_o(p_vld_o), .p_last_o(p_last_o), .p_rdy_i(p_rdy_i),
    .u_data_o(u_data_o), .u_vld_o(u_vld_o), .u_last_o(u_last_o), .u_rdy_i(u_rdy_i)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Model: shadow banks, queue of beats still owed, count of committed operand pairs.
  int sh_p [2][N];
  int sh_u [2][N];
  int m_wb = 0;
  int pending = 0;
  bit err_m = 1'b0;
  bit chk_next = 1'b0;
  bit exp_vld_next = 1'b0;
  int exp_p[$], exp_u[$], exp_l[$];
  int log_p[$], log_u[$], log_l[$], log_c[$];
  bit m_fire, m_full, m_last;

  localparam logic [19:0] PA = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [3:0]  UA = 4'b1101;
  localparam logic [19:0] PB = {5'd8, 5'd7, 5'd6, 5'd5};
  localparam logic [3:0]  UB = 4'b0110;
  localparam logic [19:0] PC = {5'd12, 5'd11, 5'd10, 5'd9};
  localparam logic [3:0]  UC = 4'b0100;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare against the model every cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (mon_en) begin
      check("lockstep_vld", u_vld_o, p_vld_o);
      check("lockstep_last", u_last_o, p_last_o);
      check("busy_vs_vld", busy_o, p_vld_o);
      check("bank_full", bank_full_o, (pending == 2) ? 1 : 0);
      check("err", err_o, err_m);
      if (chk_next) begin
        check("vld_after_last", p_vld_o, exp_vld_next);
        chk_next = 1'b0;
      end
      if (p_vld_o) begin
        if (exp_p.size() == 0) begin
          check("spurious_vld", 1, 0);
        end else begin
          check("p_data", p_data_o, exp_p[0]);
          check("u_data", u_data_o, exp_u[0]);
          check("last", p_last_o, exp_l[0]);
        end
      end
      if (s_rst_i) begin
        exp_p.delete(); exp_u.delete(); exp_l.delete();
        pending = 0; m_wb = 0; err_m = 1'b0; chk_next = 1'b0;
      end else begin
        m_fire = p_vld_o & p_rdy_i & u_rdy_i;
        m_full = (pending == 2);
        if (m_fire && exp_p.size() > 0) begin
          log_p.push_back(p_data_o); log_u.push_back(u_data_o);
          log_l.push_back(p_last_o); log_c.push_back(cyc);
          m_last = (exp_l[0] != 0);
          void'(exp_p.pop_front()); void'(exp_u.pop_front()); void'(exp_l.pop_front());
          if (m_last) begin
            pending--;
            chk_next = 1'b1;
            exp_vld_next = (exp_p.size() > 0);
          end
        end
        if (p_vld_o && (p_rdy_i != u_rdy_i)) err_m = 1'b1;
        if (wr_en_i && !m_full) begin
          if (wr_sel_i) sh_u[m_wb][wr_addr_i] = int'(wr_data_i[0]);
          else          sh_p[m_wb][wr_addr_i] = int'(wr_data_i);
        end
        if (commit_i && !m_full) begin
          for (int k = 0; k < N; k++) begin
            exp_p.push_back(sh_p[m_wb][k]);
            exp_u.push_back(sh_u[m_wb][k]);
            exp_l.push_back((k == N - 1) ? 1 : 0);
          end
          pending++;
          m_wb ^= 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic sel, input int addr, input int data);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_addr_i = addr[AW-1:0]; wr_data_i = data[QW-1:0];
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic load(input logic [19:0] pv, input logic [3:0] uv);
    for (int k = 0; k < N; k++) begin
      wr(1'b0, k, int'(pv[k*5 +: 5]));
      wr(1'b1, k, int'(uv[k]));
    end
  endtask

  task automatic do_commit();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
  endtask

  task automatic set_rdy(input logic p, input logic u);
    p_rdy_i = p; u_rdy_i = u;
  endtask

  task automatic clr_logs();
    log_p.delete(); log_u.delete(); log_l.delete(); log_c.delete();
  endtask

  task automatic wait_drain(input string nm, input int limit);
    int k;
    k = 0;
    while ((exp_p.size() != 0 || p_vld_o) && k < limit) begin
      tick();
      k++;
    end
    if (k >= limit) check({nm, "_drain_timeout"}, 1, 0);
  endtask

  task automatic check_beat(input string nm, input int i, input int p, input int u, input int l);
    if (i < log_p.size()) begin
      check({nm, "_p"}, log_p[i], p);
      check({nm, "_u"}, log_u[i], u);
      check({nm, "_last"}, log_l[i], l);
    end else begin
      check({nm, "_missing_beat"}, log_p.size(), i + 1);
    end
  endtask

  task automatic check_pair(input string nm, input int base, input logic [19:0] pv, input logic [3:0] uv);
    for (int k = 0; k < N; k++)
      check_beat(nm, base + k, int'(pv[k*5 +: 5]), int'(uv[k]), (k == N - 1) ? 1 : 0);
  endtask

  initial begin
    int k;
    tick(); tick();
    check("rst_vld", p_vld_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_full", bank_full_o, 0);
    check("rst_err", err_o, 0);
    check("rst_pdata", p_data_o, 0);
    check("rst_last", p_last_o, 0);
    s_rst_i = 1'b0;
    mon_en = 1'b1;

    // 1: single pair, rdy=1, latency commit -> vld two cycles later
    clr_logs();
    set_rdy(1, 1);
    load(PA, UA);
    do_commit();
    check("s1_vld_t1", p_vld_o, 0);
    tick();
    check("s1_vld_t2", p_vld_o, 1);
    check("s1_first_p", p_data_o, 1);
    check("s1_first_u", u_data_o, 1);
    wait_drain("s1", 20);
    check("s1_nbeats", log_p.size(), 4);
    check_beat("s1_b0", 0, 1, 1, 0);
    check_beat("s1_b1", 1, 2, 0, 0);
    check_beat("s1_b2", 2, 3, 1, 0);
    check_beat("s1_b3", 3, 4, 1, 1);
    check("s1_contig", (log_c.size() == 4) ? log_c[3] - log_c[0] : -1, 3);

    // 2: two pairs back to back, no bubble between them
    clr_logs();
    set_rdy(0, 0);
    load(PA, UA);
    do_commit();
    load(PB, UB);
    do_commit();
    check("s2_full", bank_full_o, 1);
    set_rdy(1, 1);
    wait_drain("s2", 40);
    check("s2_nbeats", log_p.size(), 8);
    check_pair("s2_a", 0, PA, UA);
    check_beat("s2_b0", 4, 5, 0, 0);
    check_beat("s2_b3", 7, 8, 0, 1);
    check("s2_contig", (log_c.size() == 8) ? log_c[7] - log_c[0] : -1, 7);
    check("s2_full_after", bank_full_o, 0);

    // 3: rdy pattern 1,0,0,1 - data held while stalled
    clr_logs();
    set_rdy(0, 0);
    load(PA, UA);
    do_commit();
    k = 0;
    while ((exp_p.size() != 0 || p_vld_o) && k < 60) begin
      set_rdy((k % 4 == 0) || (k % 4 == 3), (k % 4 == 0) || (k % 4 == 3));
      tick();
      k++;
    end
    if (k >= 60) check("s3_drain_timeout", 1, 0);
    set_rdy(1, 1);
    check("s3_nbeats", log_p.size(), 4);
    check_beat("s3_b0", 0, 1, 1, 0);
    check_beat("s3_b3", 3, 4, 1, 1);

    // 4: writes and commit ignored while both banks are loaded
    clr_logs();
    set_rdy(0, 0);
    load(PA, UA);
    do_commit();
    load(PB, UB);
    do_commit();
    check("s4_full", bank_full_o, 1);
    wr(1'b0, 0, 31);
    do_commit();
    check("s4_full_hold", bank_full_o, 1);
    set_rdy(1, 1);
    wait_drain("s4", 40);
    for (int j = 0; j < 10; j++) tick();
    check("s4_nbeats", log_p.size(), 8);
    check_beat("s4_a0", 0, 1, 1, 0);
    check_pair("s4_b", 4, PB, UB);

    // 5: rdy mismatch sets sticky err with no beat
    clr_logs();
    set_rdy(0, 0);
    load(PA, UA);
    do_commit();
    k = 0;
    while (!p_vld_o && k < 10) begin tick(); k++; end
    check("s5_vld_seen", p_vld_o, 1);
    set_rdy(1, 0);
    tick();
    check("s5_err_set", err_o, 1);
    check("s5_no_beat", log_p.size(), 0);
    set_rdy(0, 0);
    tick();
    check("s5_err_sticky", err_o, 1);
    set_rdy(1, 1);
    wait_drain("s5", 20);
    check("s5_nbeats", log_p.size(), 4);
    check_beat("s5_b0", 0, 1, 1, 0);
    check("s5_err_end", err_o, 1);

    // 6: reset mid-stream, then a fresh load streams from coeff 0
    s_rst_i = 1'b1;
    tick();
    s_rst_i = 1'b0;
    check("s6_err_clr", err_o, 0);
    clr_logs();
    set_rdy(0, 0);
    load(PA, UA);
    do_commit();
    load(PB, UB);
    do_commit();
    set_rdy(1, 1);
    k = 0;
    while (log_p.size() < 2 && k < 20) begin tick(); k++; end
    check("s6_two_beats", log_p.size(), 2);
    set_rdy(0, 0);
    s_rst_i = 1'b1;
    tick();
    s_rst_i = 1'b0;
    check("s6_vld", p_vld_o, 0);
    check("s6_busy", busy_o, 0);
    check("s6_full", bank_full_o, 0);
    clr_logs();
    load(PC, UC);
    do_commit();
    set_rdy(1, 1);
    wait_drain("s6", 20);
    check("s6_nbeats", log_p.size(), 4);
    check_beat("s6_c0", 0, 9, 0, 0);
    check_beat("s6_c2", 2, 11, 1, 0);
    check_beat("s6_c3", 3, 12, 0, 1);

    tick();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
